// File: rtl/rtc_bus_ctl_if.sv
// rtc_bus_ctl_if: host request/response and RTC chip bus signals of the RTC bus controller
interface rtc_bus_ctl_if;
  logic req, we, ack, busy;
  logic [4:0] addr, rtc_a;
  logic [7:0] wdata, rdata, rtc_d_out, rtc_d_in;
  logic rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_d_oe;
  modport slave(
    input req, we, addr, wdata, rtc_d_in,
    output rdata, ack, busy, rtc_a, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_d_out, rtc_d_oe
  );
  modport master(
    output req, we, addr, wdata, rtc_d_in,
    input rdata, ack, busy, rtc_a, rtc_cs_n, rtc_rd_n, rtc_wr_n, rtc_d_out, rtc_d_oe
  );
endinterface

// File: rtl/rtc_bus_ctl.sv
// rtc_bus_ctl: sequences setup/strobe/hold timing of single reads and writes to a parallel-bus RTC chip
module rtc_bus_ctl #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input logic clk,
  input logic reset_n,
  rtc_bus_ctl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_e;
  localparam logic [3:0] SETUP_L  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_L = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_L   = 4'(HOLD_CYC - 1);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic [4:0] a_q, a_d;
  logic [7:0] dout_q, dout_d, rdata_q, rdata_d;
  logic cs_n_q, rd_n_q, wr_n_q, oe_q, ack_q, busy_q;
  logic accept, last;
  always_comb begin
    accept  = state_q == IDLE && bus.req;
    last    = cnt_q == 4'd0;
    state_d = state_q;
    cnt_d   = last ? 4'd0 : cnt_q - 4'd1;
    we_d    = accept ? bus.we : we_q;
    a_d     = accept ? bus.addr : a_q;
    dout_d  = accept ? bus.wdata : dout_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (bus.req) begin
        state_d = SETUP;
        cnt_d   = SETUP_L;
      end
      SETUP: if (last) begin
        state_d = STROBE;
        cnt_d   = STROBE_L;
      end
      STROBE: if (last) begin
        state_d = HOLD;
        cnt_d   = HOLD_L;
        rdata_d = we_q ? rdata_q : bus.rtc_d_in;
      end
      HOLD: if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      a_q     <= 5'd0;
      dout_q  <= 8'd0;
      rdata_q <= 8'd0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      a_q     <= a_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      cs_n_q  <= state_d == IDLE;
      rd_n_q  <= !(state_d == STROBE && !we_d);
      wr_n_q  <= !(state_d == STROBE && we_d);
      oe_q    <= we_d && (state_d inside {SETUP, STROBE, HOLD});
      ack_q   <= state_d == DONE;
      busy_q  <= state_d != IDLE;
    end
  end
  assign bus.rdata     = rdata_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.rtc_a     = a_q;
  assign bus.rtc_cs_n  = cs_n_q;
  assign bus.rtc_rd_n  = rd_n_q;
  assign bus.rtc_wr_n  = wr_n_q;
  assign bus.rtc_d_out = dout_q;
  assign bus.rtc_d_oe  = oe_q;
endmodule

// File: tb/tb_rtc_bus_ctl.sv
// tb_rtc_bus_ctl: directed checks of rtc_bus_ctl at default, minimum and maximum timing parameters
module tb_rtc_bus_ctl;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req = 1'b0, we = 1'b0;
  logic [4:0] addr = 5'd0;
  logic [7:0] wdata = 8'd0, din = 8'd0;
  int sel = 0;
  int n_chk = 0, n_fail = 0;
  int cs_cnt, rd_first, rd_last, wr_first, wr_last, oe_cnt, ack_cnt, ack_k, bad_a, bad_d, idle_cnt, n_ack;
  rtc_bus_ctl_if b0(), b1(), b2();
  rtc_bus_ctl u0 (.clk(clk), .reset_n(reset_n), .bus(b0.slave));
  rtc_bus_ctl #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
  rtc_bus_ctl #(.SETUP_CYC(15), .STROBE_CYC(15), .HOLD_CYC(15)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2.slave));
  always #5 clk = ~clk;
  assign b0.req = req && sel == 0;
  assign b1.req = req && sel == 1;
  assign b2.req = req && sel == 2;
  assign b0.we = we;
  assign b1.we = we;
  assign b2.we = we;
  assign b0.addr = addr;
  assign b1.addr = addr;
  assign b2.addr = addr;
  assign b0.wdata = wdata;
  assign b1.wdata = wdata;
  assign b2.wdata = wdata;
  assign b0.rtc_d_in = din;
  assign b1.rtc_d_in = din;
  assign b2.rtc_d_in = din;
  logic [26:0] ov [3];
  assign ov[0] = {b0.rdata, b0.ack, b0.busy, b0.rtc_a, b0.rtc_cs_n, b0.rtc_rd_n, b0.rtc_wr_n, b0.rtc_d_out, b0.rtc_d_oe};
  assign ov[1] = {b1.rdata, b1.ack, b1.busy, b1.rtc_a, b1.rtc_cs_n, b1.rtc_rd_n, b1.rtc_wr_n, b1.rtc_d_out, b1.rtc_d_oe};
  assign ov[2] = {b2.rdata, b2.ack, b2.busy, b2.rtc_a, b2.rtc_cs_n, b2.rtc_rd_n, b2.rtc_wr_n, b2.rtc_d_out, b2.rtc_d_oe};
  logic [7:0] rdata, d_out;
  logic [4:0] a;
  logic ack, busy, cs_n, rd_n, wr_n, oe;
  assign {rdata, ack, busy, a, cs_n, rd_n, wr_n, d_out, oe} = ov[sel];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // One access; capk is the cycle index whose rtc_d_in the capture edge samples, win bounds the observation.
  task automatic access(input logic w, input logic [4:0] ad, input logic [7:0] wd, input logic [7:0] de,
                        input logic [7:0] dl, input int capk, input int pulse_k, input int win,
                        input int ack_win, input logic hold);
    @(negedge clk);
    req = 1'b1; we = w; addr = ad; wdata = wd; din = de;
    cs_cnt = 0; rd_first = -1; rd_last = -1; wr_first = -1; wr_last = -1;
    oe_cnt = 0; ack_cnt = 0; ack_k = -1; bad_a = 0; bad_d = 0; idle_cnt = 0;
    @(posedge clk);
    #1 req = hold;
    for (int k = 0; k < win; k++) begin
      @(negedge clk);
      din = (k == capk) ? dl : de;
      req = hold || (k + 1 == pulse_k);
      if (!cs_n) begin
        cs_cnt++;
        if (a != ad) bad_a++;
      end
      if (!rd_n) begin
        if (rd_first < 0) rd_first = k;
        rd_last = k;
      end
      if (!wr_n) begin
        if (wr_first < 0) wr_first = k;
        wr_last = k;
      end
      if (oe) begin
        oe_cnt++;
        if (d_out != wd) bad_d++;
      end
      if (ack) begin
        ack_cnt++;
        ack_k = k;
      end
      if (!busy && k < ack_win) idle_cnt++;
    end
    req = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_rd_n", rd_n, 1);
    chk("rst_wr_n", wr_n, 1);
    chk("rst_oe", oe, 0);
    chk("rst_a", a, 0);
    chk("rst_dout", d_out, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    access(1'b0, 5'h05, 8'h00, 8'h11, 8'h37, 5, -1, 12, 8, 1'b0);
    chk("rd_cs_cycles", cs_cnt, 9);
    chk("rd_strobe_first", rd_first, 2);
    chk("rd_strobe_last", rd_last, 5);
    chk("rd_wr_n_high", wr_first, -1);
    chk("rd_oe_low", oe_cnt, 0);
    chk("rd_addr", bad_a, 0);
    chk("rd_ack_count", ack_cnt, 1);
    chk("rd_ack_cycle", ack_k, 8);
    chk("rd_busy", idle_cnt, 0);
    chk("rd_rdata", rdata, 8'h37);
    access(1'b1, 5'h1F, 8'hA5, 8'h00, 8'hFF, 5, -1, 12, 8, 1'b0);
    chk("wr_strobe_first", wr_first, 2);
    chk("wr_strobe_last", wr_last, 5);
    chk("wr_rd_n_high", rd_first, -1);
    chk("wr_oe_cycles", oe_cnt, 8);
    chk("wr_dout", bad_d, 0);
    chk("wr_addr", bad_a, 0);
    chk("wr_cs_cycles", cs_cnt, 9);
    chk("wr_ack_cycle", ack_k, 8);
    chk("wr_rdata_kept", rdata, 8'h37);
    access(1'b0, 5'h02, 8'h00, 8'h44, 8'h44, 5, 3, 20, 8, 1'b0);
    chk("busy_req_acks", ack_cnt, 1);
    chk("busy_req_cs", cs_cnt, 9);
    access(1'b0, 5'h04, 8'h00, 8'h21, 8'h21, 5, -1, 20, 18, 1'b1);
    chk("b2b_acks", ack_cnt, 2);
    chk("b2b_ack2_cycle", ack_k, 18);
    chk("b2b_idle_cycles", idle_cnt, 1);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 5'h0A; din = 8'h5A;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_in_strobe", rd_n, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rd_n", rd_n, 1);
    chk("mid_cs_n", cs_n, 1);
    chk("mid_busy", busy, 0);
    chk("mid_a", a, 0);
    @(negedge clk);
    reset_n = 1'b1;
    n_ack = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ack) n_ack++;
    end
    chk("mid_no_ack", n_ack, 0);
    chk("mid_rdata", rdata, 0);
    access(1'b0, 5'h03, 8'h00, 8'h11, 8'h6C, 5, -1, 12, 8, 1'b0);
    chk("post_ack_cycle", ack_k, 8);
    chk("post_rdata", rdata, 8'h6C);
    sel = 1;
    access(1'b0, 5'h07, 8'h00, 8'h0F, 8'hC3, 1, -1, 8, 3, 1'b0);
    chk("min_strobe_first", rd_first, 1);
    chk("min_strobe_last", rd_last, 1);
    chk("min_ack_cycle", ack_k, 3);
    chk("min_ack_count", ack_cnt, 1);
    chk("min_cs_cycles", cs_cnt, 4);
    chk("min_rdata", rdata, 8'hC3);
    sel = 2;
    access(1'b1, 5'h10, 8'h5C, 8'h00, 8'h00, 29, -1, 50, 45, 1'b0);
    chk("max_strobe_first", wr_first, 15);
    chk("max_strobe_last", wr_last, 29);
    chk("max_ack_cycle", ack_k, 45);
    chk("max_ack_count", ack_cnt, 1);
    chk("max_oe_cycles", oe_cnt, 45);
    chk("max_cs_cycles", cs_cnt, 46);
    chk("max_busy", idle_cnt, 0);
    chk("max_dout", bad_d, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
